id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage of the pipelined MIPS core, directly upstream of the ALU.
- Captures decoded operands and control each cycle.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Drives the ALU A, B and F inputs, and flags load-use hazards back to the hazard unit.

---
 rtl/id_ex_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
// Define IDEX_FORWARD_EN for MEM/WB forwarding; otherwise lu_stall covers every pending write.
module id_ex_stage #(
  parameter int LOGWIDTH = 5,
  parameter int REGBITS  = 5,
  localparam int W = 2 ** LOGWIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_e,
  input  logic               flush_e,
  input  logic [W-1:0]       id_rd1,
  input  logic [W-1:0]       id_rd2,
  input  logic [W-1:0]       id_imm,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic [REGBITS-1:0] id_rd,
  input  logic [2:0]         id_alu_f,
  input  logic               id_alusrc,
  input  logic               id_regdst,
  input  logic               id_regwrite,
  input  logic               id_memtoreg,
  input  logic               id_memwrite,
  input  logic               id_valid,
  input  logic               mem_regwrite,
  input  logic [REGBITS-1:0] mem_writereg,
  input  logic [W-1:0]       mem_aluout,
  input  logic               wb_regwrite,
  input  logic [REGBITS-1:0] wb_writereg,
  input  logic [W-1:0]       wb_result,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic [2:0]         alu_f,
  output logic [W-1:0]       ex_writedata,
  output logic [REGBITS-1:0] ex_writereg,
  output logic               ex_regwrite,
  output logic               ex_memtoreg,
  output logic               ex_memwrite,
  output logic               ex_valid,
  output logic               lu_stall
);

  logic [W-1:0]       rd1_q, rd2_q, imm_q;
  logic [REGBITS-1:0] rs_q, rt_q, rd_q;
  logic [2:0]         f_q;
  logic               alusrc_q, regdst_q, regwrite_q, memtoreg_q, memwrite_q, valid_q;
  logic [W-1:0]       fwd_a, fwd_b;

  // Flush clears data fields too so a bubble is bit-for-bit identical to reset.
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      f_q        <= '0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (!stall_e) begin
      rd1_q      <= id_rd1;
      rd2_q      <= id_rd2;
      imm_q      <= id_imm;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      rd_q       <= id_rd;
      f_q        <= id_alu_f;
      alusrc_q   <= id_alusrc;
      regdst_q   <= id_regdst;
      regwrite_q <= id_regwrite;
      memtoreg_q <= id_memtoreg;
      memwrite_q <= id_memwrite;
      valid_q    <= id_valid;
    end
  end

  assign ex_writereg = regdst_q ? rd_q : rt_q;

`ifdef IDEX_FORWARD_EN
  // MEM is younger than WB, so its value wins when both target the same register.
  always_comb begin
    fwd_a = rd1_q;
    if (rs_q != '0 && mem_regwrite && mem_writereg == rs_q)
      fwd_a = mem_aluout;
    else if (rs_q != '0 && wb_regwrite && wb_writereg == rs_q)
      fwd_a = wb_result;
  end

  always_comb begin
    fwd_b = rd2_q;
    if (rt_q != '0 && mem_regwrite && mem_writereg == rt_q)
      fwd_b = mem_aluout;
    else if (rt_q != '0 && wb_regwrite && wb_writereg == rt_q)
      fwd_b = wb_result;
  end

  assign lu_stall = valid_q & memtoreg_q & (rt_q != '0) &
                    ((rt_q == id_rs) | (rt_q == id_rt));
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_regwrite, mem_writereg, mem_aluout,
                               wb_regwrite, wb_writereg, wb_result, rs_q};

  assign fwd_a = rd1_q;
  assign fwd_b = rd2_q;

  // Without bypass paths any in-flight write must drain before a dependent reads.
  assign lu_stall = valid_q & regwrite_q & (ex_writereg != '0) &
                    ((ex_writereg == id_rs) | (ex_writereg == id_rt));
`endif

  assign alu_a        = fwd_a;
  assign alu_b        = alusrc_q ? imm_q : fwd_b;
  assign alu_f        = f_q;
  assign ex_writedata = fwd_b;
  assign ex_regwrite  = regwrite_q;
  assign ex_memtoreg  = memtoreg_q;
  assign ex_memwrite  = memwrite_q;
  assign ex_valid     = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [2:0]  id_alu_f;
  logic        id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite, id_valid;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_writereg, wb_writereg;
  logic [31:0] mem_aluout, wb_result;
  logic [31:0] alu_a, alu_b, ex_writedata;
  logic [2:0]  alu_f;
  logic [4:0]  ex_writereg;
  logic        ex_regwrite, ex_memtoreg, ex_memwrite, ex_valid, lu_stall;

  int checks = 0;
  int errors = 0;
  logic [107:0] sbq[$];
  logic [107:0] e;
  logic         exp_bit;
  logic [31:0]  exp_word;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_f(id_alu_f),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_valid(id_valid),
    .mem_regwrite(mem_regwrite), .mem_writereg(mem_writereg), .mem_aluout(mem_aluout),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .ex_writedata(ex_writedata),
    .ex_writereg(ex_writereg), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_valid(ex_valid), .lu_stall(lu_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [107:0] pack_out();
    return {alu_a, alu_b, ex_writedata, ex_writereg, alu_f,
            ex_regwrite, ex_memtoreg, ex_memwrite, ex_valid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [2:0] f, input logic alusrc, input logic regdst,
                        input logic rw, input logic mt, input logic mw, input logic v);
    id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_alu_f = f;
    id_alusrc = alusrc; id_regdst = regdst;
    id_regwrite = rw; id_memtoreg = mt; id_memwrite = mw; id_valid = v;
  endtask

  task automatic no_bypass();
    mem_regwrite = 1'b0; mem_writereg = 5'd0; mem_aluout = 32'd0;
    wb_regwrite = 1'b0; wb_writereg = 5'd0; wb_result = 32'd0;
  endtask

  task automatic test_reset();
    stall_e = 1'b0; flush_e = 1'b0; no_bypass();
    set_id(32'h1234, 32'h5678, 32'h9ABC, 5'd1, 5'd2, 5'd3, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    step();
    sbq.push_back('0);
    e = sbq.pop_front();
    checks++;
    if (pack_out() !== e) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", pack_out(), e);
    end
    checks++;
    if (lu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_lu_stall got %b exp 0", lu_stall);
    end
    reset = 1'b0;
  endtask

  task automatic test_plain_load();
    set_id(32'd5, 32'd7, 32'h1234, 5'd1, 5'd2, 5'd3, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    sbq.push_back({32'd5, 32'd7, 32'd7, 5'd3, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1});
    step();
    e = sbq.pop_front();
    checks++;
    if (pack_out() !== e) begin
      errors++;
      $display("FAIL plain_load got %h exp %h", pack_out(), e);
    end
    checks++;
    if (lu_stall !== 1'b0) begin
      errors++;
      $display("FAIL plain_load_lu_stall got %b exp 0", lu_stall);
    end
  endtask

  task automatic test_imm_dest();
    set_id(32'h10, 32'hABCD, 32'hFFFFFFFC, 5'd8, 5'd9, 5'd12, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    sbq.push_back({32'h10, 32'hFFFFFFFC, 32'hABCD, 5'd9, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1});
    step();
    e = sbq.pop_front();
    checks++;
    if (pack_out() !== e) begin
      errors++;
      $display("FAIL imm_rt_dest got %h exp %h", pack_out(), e);
    end
    // store: immediate B, rt data on writedata, rd selected
    set_id(32'h40, 32'hCAFE, 32'h8, 5'd10, 5'd11, 5'd31, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    sbq.push_back({32'h40, 32'h8, 32'hCAFE, 5'd31, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1});
    step();
    e = sbq.pop_front();
    checks++;
    if (pack_out() !== e) begin
      errors++;
      $display("FAIL store_rd_dest got %h exp %h", pack_out(), e);
    end
  endtask

  task automatic test_forwarding();
    set_id(32'hAA, 32'hBB, 32'h4, 5'd3, 5'd5, 5'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mem_regwrite = 1'b1; mem_writereg = 5'd3; mem_aluout = 32'h11;
    wb_regwrite = 1'b1; wb_writereg = 5'd3; wb_result = 32'h22;
    step();
`ifdef IDEX_FORWARD_EN
    exp_word = 32'h11;
`else
    exp_word = 32'hAA;
`endif
    checks++;
    if (alu_a !== exp_word) begin
      errors++;
      $display("FAIL fwd_mem_priority got %h exp %h", alu_a, exp_word);
    end
    mem_regwrite = 1'b0;
    #1;
`ifdef IDEX_FORWARD_EN
    exp_word = 32'h22;
`else
    exp_word = 32'hAA;
`endif
    checks++;
    if (alu_a !== exp_word) begin
      errors++;
      $display("FAIL fwd_wb got %h exp %h", alu_a, exp_word);
    end
    wb_writereg = 5'd5;
#1;
`ifdef IDEX_FORWARD_EN
    exp_word = 32'h22;
`else
    exp_word = 32'hBB;
`endif
    checks++;
    if (alu_b !== exp_word || ex_writedata !== exp_word) begin
      errors++;
      $display("FAIL fwd_b got alu_b %h writedata %h exp %h", alu_b, ex_writedata, exp_word);
    end
    // index 0 never forwards
    set_id(32'h77, 32'h88, 32'h4, 5'd0, 5'd0, 5'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mem_regwrite = 1'b1; mem_writereg = 5'd0; wb_regwrite = 1'b1; wb_writereg = 5'd0;
    step();
    checks++;
    if (alu_a !== 32'h77 || alu_b !== 32'h88) begin
      errors++;
      $display("FAIL fwd_reg0 got a %h b %h exp 77 88", alu_a, alu_b);
    end
    no_bypass();
  endtask

  task automatic test_load_use();
    set_id(32'h0, 32'h0, 32'h0, 5'd1, 5'd4, 5'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    id_rs = 5'd7; id_rt = 5'd4; #1;
    checks++;
    if (lu_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_rt_match got %b exp 1", lu_stall);
    end
    id_rs = 5'd4; id_rt = 5'd6; #1;
    checks++;
    if (lu_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_rs_match got %b exp 1", lu_stall);
    end
    id_rs = 5'd5; id_rt = 5'd6; #1;
    checks++;
    if (lu_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_no_match got %b exp 0", lu_stall);
    end
    set_id(32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    id_rs = 5'd0; id_rt = 5'd0; #1;
    checks++;
    if (lu_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_reg0 got %b exp 0", lu_stall);
    end
    // plain ALU write to rd=6: only a hazard when there is no bypass path
    set_id(32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd6, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    id_rs = 5'd6; id_rt = 5'd9; #1;
`ifdef IDEX_FORWARD_EN
    exp_bit = 1'b0;
`else
    exp_bit = 1'b1;
`endif
    checks++;
    if (lu_stall !== exp_bit) begin
      errors++;
      $display("FAIL lu_alu_write got %b exp %b", lu_stall, exp_bit);
    end
  endtask

  task automatic test_flush_stall();
    set_id(32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    stall_e = 1'b1; flush_e = 1'b1;
    sbq.push_back('0);
    step();
    e = sbq.pop_front();
    checks++;
    if (pack_out() !== e) begin
      errors++;
      $display("FAIL flush_beats_stall got %h exp %h", pack_out(), e);
    end
    stall_e = 1'b0; flush_e = 1'b0;
    set_id(32'h51, 32'h52, 32'h53, 5'd11, 5'd12, 5'd13, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id($urandom, $urandom, $urandom, 5'(i + 20), 5'(i + 23), 5'(i + 26), 3'(i),
             1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      sbq.push_back({32'h51, 32'h52, 32'h52, 5'd13, 3'b100, 1'b1, 1'b0, 1'b0, 1'b1});
      step();
      e = sbq.pop_front();
      checks++;
      if (pack_out() !== e) begin
        errors++;
        $display("FAIL stall_hold_%0d got %h exp %h", i, pack_out(), e);
      end
    end
    reset = 1'b1;
    sbq.push_back('0);
    step();
    e = sbq.pop_front();
    checks++;
    if (pack_out() !== e) begin
      errors++;
      $display("FAIL reset_mid_stall got %h exp %h", pack_out(), e);
    end
    reset = 1'b0; stall_e = 1'b0;
    set_id(32'h61, 32'h62, 32'h63, 5'd1, 5'd2, 5'd3, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    flush_e = 1'b1;
    sbq.push_back('0);
    step();
    e = sbq.pop_front();
    checks++;
    if (pack_out() !== e) begin
      errors++;
      $display("FAIL flush_only got %h exp %h", pack_out(), e);
    end
    flush_e = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    test_reset();
    test_plain_load();
    test_imm_dest();
    test_forwarding();
    test_load_use();
    test_flush_stall();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
